// File: rtl/uart_pkg.sv
// Shared state encoding, framing constants and parity helper for the UART transmit path.
package uart_pkg;

    // PARITY is always present so the encoding does not depend on the build.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_state_t;

    localparam int   UART_DATA_BITS  = 8;
    localparam logic UART_IDLE_LEVEL = 1'b1;

    function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with a wrap bit on each pointer; head entry is read combinationally.
module uart_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wptr_r;
    logic [AW:0]      rptr_r;
    logic [AW:0]      level_r;
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic             push_ok_s;
    logic             pop_ok_s;

    assign empty     = (wptr_r == rptr_r);
    assign full      = (wptr_r[AW] != rptr_r[AW]) && (wptr_r[AW-1:0] == rptr_r[AW-1:0]);
    assign rdata     = mem_r[rptr_r[AW-1:0]];
    assign level     = level_r;
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_r  <= '0;
            rptr_r  <= '0;
            level_r <= '0;
        end else begin
            if (push_ok_s) begin
                wptr_r <= wptr_r + 1'b1;
            end
            if (pop_ok_s) begin
                rptr_r <= rptr_r + 1'b1;
            end
            if (push_ok_s && !pop_ok_s) begin
                level_r <= level_r + 1'b1;
            end else if (pop_ok_s && !push_ok_s) begin
                level_r <= level_r - 1'b1;
            end else begin
                level_r <= level_r;
            end
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wptr_r[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART 8N1 transmitter fed by a small FIFO; define UART_TX_PARITY_EN to add an even-parity bit.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ena,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int                 CW        = $clog2(CLKS_PER_BIT);
    localparam int                 BW        = $clog2(UART_DATA_BITS);
    localparam logic [CW-1:0]      BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0]      BIT_LAST  = BW'(UART_DATA_BITS - 1);

    uart_tx_state_t              state_r;
    uart_tx_state_t              state_nxt_s;
    logic [CW-1:0]               baud_cnt_r;
    logic [CW-1:0]               baud_cnt_nxt_s;
    logic [BW-1:0]               bit_cnt_r;
    logic [BW-1:0]               bit_cnt_nxt_s;
    logic [UART_DATA_BITS-1:0]   shift_r;
    logic [UART_DATA_BITS-1:0]   shift_nxt_s;
    logic                        tx_r;
    logic                        tx_nxt_s;
    logic [UART_DATA_BITS-1:0]   head_s;
    logic                        full_s;
    logic                        empty_s;
    logic                        push_s;
    logic                        pop_s;
    logic                        wrap_s;
`ifdef UART_TX_PARITY_EN
    logic                        par_r;
    logic                        par_nxt_s;
`endif

    assign in_ready = ena && !full_s;
    assign push_s   = in_valid && in_ready;
    assign wrap_s   = (baud_cnt_r == BAUD_LAST);
    assign busy     = (state_r != IDLE) || !empty_s;
    assign tx       = tx_r;

    uart_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_BITS)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (in_data),
        .rdata (head_s),
        .full  (full_s),
        .empty (empty_s),
        .level (level)
    );

    // FSM state, baud/bit counters, shift register and line register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            baud_cnt_r <= '0;
            bit_cnt_r  <= '0;
            shift_r    <= '0;
            tx_r       <= UART_IDLE_LEVEL;
        end else begin
            state_r    <= state_nxt_s;
            baud_cnt_r <= baud_cnt_nxt_s;
            bit_cnt_r  <= bit_cnt_nxt_s;
            shift_r    <= shift_nxt_s;
            tx_r       <= tx_nxt_s;
        end
    end

    // Next-state and pop decision; STOP chains straight into START when data is waiting.
    always_comb begin
        state_nxt_s = state_r;
        pop_s       = 1'b0;
        if (ena) begin
            case (state_r)
                IDLE: begin
                    if (!empty_s) begin
                        state_nxt_s = START;
                        pop_s       = 1'b1;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                START: begin
                    if (wrap_s) begin
                        state_nxt_s = DATA;
                    end else begin
                        state_nxt_s = START;
                    end
                end
                DATA: begin
                    if (wrap_s && (bit_cnt_r == BIT_LAST)) begin
`ifdef UART_TX_PARITY_EN
                        state_nxt_s = PARITY;
`else
                        state_nxt_s = STOP;
`endif
                    end else begin
                        state_nxt_s = DATA;
                    end
                end
                PARITY: begin
                    if (wrap_s) begin
                        state_nxt_s = STOP;
                    end else begin
                        state_nxt_s = PARITY;
                    end
                end
                STOP: begin
                    if (wrap_s && !empty_s) begin
                        state_nxt_s = START;
                        pop_s       = 1'b1;
                    end else if (wrap_s) begin
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = STOP;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Datapath updates and the value the line register takes for the next state.
    always_comb begin
        baud_cnt_nxt_s = baud_cnt_r;
        bit_cnt_nxt_s  = bit_cnt_r;
        shift_nxt_s    = shift_r;
        tx_nxt_s       = tx_r;
        if (ena) begin
            if (pop_s) begin
                baud_cnt_nxt_s = '0;
                bit_cnt_nxt_s  = '0;
                shift_nxt_s    = head_s;
            end else if (state_r != IDLE) begin
                if (wrap_s) begin
                    baud_cnt_nxt_s = '0;
                end else begin
                    baud_cnt_nxt_s = baud_cnt_r + 1'b1;
                end
                if ((state_r == DATA) && wrap_s) begin
                    shift_nxt_s   = shift_r >> 1;
                    bit_cnt_nxt_s = bit_cnt_r + 1'b1;
                end else begin
                    shift_nxt_s   = shift_r;
                    bit_cnt_nxt_s = bit_cnt_r;
                end
            end else begin
                baud_cnt_nxt_s = '0;
            end
            case (state_nxt_s)
                IDLE:    tx_nxt_s = UART_IDLE_LEVEL;
                START:   tx_nxt_s = 1'b0;
                DATA:    tx_nxt_s = shift_nxt_s[0];
                PARITY: begin
`ifdef UART_TX_PARITY_EN
                    tx_nxt_s = par_r;
`else
                    tx_nxt_s = UART_IDLE_LEVEL;
`endif
                end
                STOP:    tx_nxt_s = 1'b1;
                default: tx_nxt_s = UART_IDLE_LEVEL;
            endcase
        end else begin
            tx_nxt_s = tx_r;
        end
    end

`ifdef UART_TX_PARITY_EN
    // Parity is captured at pop time because the shift register is consumed by DATA.
    always_comb begin
        par_nxt_s = par_r;
        if (ena && pop_s) begin
            par_nxt_s = even_parity(head_s);
        end else begin
            par_nxt_s = par_r;
        end
    end

    // Parity bit register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_r <= 1'b0;
        end else begin
            par_r <= par_nxt_s;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: per-cycle comparison against a frame-timeline reference model.
module tb_uart_tx_fifo;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FL    = NBITS * CPB;

    logic          clk;
    logic          rst_n;
    logic          ena;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic          tx;
    logic          busy;
    logic [LW-1:0] level;

    int checks;
    int errors;

    // Reference model: queued bytes plus position inside the frame currently on the line.
    logic [7:0] mq [$];
    bit         m_active;
    int         m_pos;
    logic [7:0] m_cur;

    uart_tx_fifo #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .tx       (tx),
        .busy     (busy),
        .level    (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        else if (idx <= 8) return b[idx-1];
        else if ((idx == 9) && (NBITS == 11)) return ^b;
        else return 1'b1;
    endfunction

    function automatic logic exp_tx();
        return m_active ? frame_bit(m_cur, m_pos / CPB) : 1'b1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_advance();
        if (!m_active) begin
            if (mq.size() > 0) begin
                m_cur    = mq.pop_front();
                m_active = 1'b1;
                m_pos    = 0;
            end
        end else begin
            m_pos++;
            if (m_pos == FL) begin
                m_pos = 0;
                if (mq.size() > 0) m_cur = mq.pop_front();
                else m_active = 1'b0;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ":tx"},       32'(tx),       32'(exp_tx()));
        chk({tag, ":level"},    32'(level),    32'(mq.size()));
        chk({tag, ":busy"},     32'(busy),     32'(m_active || (mq.size() > 0)));
        chk({tag, ":in_ready"}, 32'(in_ready), 32'(ena && (mq.size() < DEPTH)));
    endtask

    // One clock: decide acceptance from the model, advance it at the edge, then compare.
    task automatic cycle(input string tag, output bit acc);
        logic [7:0] d;
        acc = (in_valid === 1'b1) && (ena === 1'b1) && (rst_n === 1'b1) && (mq.size() < DEPTH);
        d   = in_data;
        @(posedge clk);
        if ((rst_n === 1'b1) && (ena === 1'b1)) begin
            model_advance();
            if (acc) mq.push_back(d);
        end
        #1;
        check_outputs(tag);
    endtask

    task automatic step(input string tag);
        bit a;
        cycle(tag, a);
    endtask

    task automatic bound_fail(input string tag);
        checks++;
        errors++;
        $error("FAIL %s observed=timeout expected=event", tag);
    endtask

    task automatic wait_pos(input string tag, input int target);
        int n;
        n = 0;
        while (!(m_active && (m_pos == target)) && (n < 5000)) begin
            step(tag);
            n++;
        end
        if (n >= 5000) bound_fail(tag);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((m_active || (mq.size() > 0)) && (n < 5000)) begin
            step(tag);
            n++;
        end
        if (n >= 5000) bound_fail(tag);
        repeat (3) step(tag);
    endtask

    task automatic send_one(input string tag, input logic [7:0] b);
        bit a;
        in_data  = b;
        in_valid = 1'b1;
        cycle(tag, a);
        in_valid = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] pat;
        logic [7:0]  bytes [6];
        int          idx;
        bit          acc;

        checks   = 0;
        errors   = 0;
        m_active = 1'b0;
        m_pos    = 0;
        m_cur    = 8'h00;
        rst_n    = 1'b1;
        ena      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;

        // Reset state; in_ready follows ena while reset is held.
        #2 rst_n = 1'b0;
        #1;
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_ready_ena1", 32'(in_ready), 32'd1);
        ena = 1'b0;
        #1;
        chk("rst_ready_ena0", 32'(in_ready), 32'd0);
        ena = 1'b1;
        step("rst_hold");
        step("rst_hold");
        #2 rst_n = 1'b1;
        repeat (3) step("idle");

        // Single byte 0xA5 from idle: latency and exact line pattern.
`ifdef UART_TX_PARITY_EN
        pat = {1'b1, 1'b0, 8'hA5, 1'b0};
`else
        pat = {1'b0, 1'b1, 8'hA5, 1'b0};
`endif
        in_data  = 8'hA5;
        in_valid = 1'b1;
        chk("a5_ready", 32'(in_ready), 32'd1);
        cycle("a5_push", acc);
        in_valid = 1'b0;
        chk("a5_level_n", 32'(level), 32'd1);
        chk("a5_tx_n", 32'(tx), 32'd1);
        chk("a5_busy_n", 32'(busy), 32'd1);
        step("a5_pop");
        chk("a5_tx_fall", 32'(tx), 32'd0);
        for (int k = 0; k < FL; k++) begin
            chk("a5_line", 32'(tx), 32'(pat[k / CPB]));
            step("a5_frame");
        end
        chk("a5_busy_drop", 32'(busy), 32'd0);
        chk("a5_tx_idle", 32'(tx), 32'd1);
        repeat (2) step("idle");

        // Parity-sensitive bytes plus a few random single bytes.
        send_one("b07", 8'h07);
        drain("b07_drain");
        send_one("b03", 8'h03);
        drain("b03_drain");
        for (int r = 0; r < 3; r++) begin
            send_one("rnd_single", 8'($urandom));
            repeat ($urandom_range(0, 5)) step("rnd_gap");
            drain("rnd_single_drain");
        end

        // Back-to-back with in_valid held; the sixth byte has to wait for space.
        bytes[0] = 8'h01; bytes[1] = 8'h02; bytes[2] = 8'h03;
        bytes[3] = 8'h04; bytes[4] = 8'h05; bytes[5] = 8'($urandom);
        idx      = 0;
        in_valid = 1'b1;
        in_data  = bytes[0];
        for (int i = 0; (i < 2000) && (idx < 6); i++) begin
            cycle("b2b", acc);
            if (acc) idx++;
            if (idx < 6) in_data = bytes[idx];
            else in_valid = 1'b0;
        end
        in_valid = 1'b0;
        if (idx < 6) bound_fail("b2b_accept");
        drain("b2b_drain");

        // Push on the last STOP cycle while one byte is queued.
        send_one("pp_a", 8'($urandom));
        step("pp_gap");
        send_one("pp_b", 8'($urandom));
        wait_pos("pp_wait", FL - 1);
        chk("pp_level_before", 32'(level), 32'd1);
        send_one("pp_c", 8'h3C);
        chk("pp_level_after", 32'(level), 32'd1);
        chk("pp_next_start", 32'(tx), 32'd0);
        drain("pp_drain");

        // ena low for 7 cycles inside data bit 3.
        send_one("gap_push", 8'($urandom));
        wait_pos("gap_wait", 4 * CPB + 1);
        ena = 1'b0;
        for (int g = 0; g < 7; g++) begin
            step("gap_off");
            chk("gap_ready", 32'(in_ready), 32'd0);
            chk("gap_tx", 32'(tx), 32'(frame_bit(m_cur, 4)));
        end
        ena = 1'b1;
        drain("gap_drain");

        // Randomized traffic with occasional ena drops.
        for (int r = 0; r < 300; r++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 8'($urandom);
            ena      = ($urandom_range(0, 7) != 0);
            step("rnd_mix");
        end
        ena      = 1'b1;
        in_valid = 1'b0;
        drain("rnd_mix_drain");

        // Asynchronous reset in the middle of a frame with two bytes queued.
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 8'($urandom);
            step("rstm_fill");
        end
        in_valid = 1'b0;
        wait_pos("rstm_wait", 3 * CPB);
        chk("rstm_level_before", 32'(level), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        mq.delete();
        m_active = 1'b0;
        m_pos    = 0;
        chk("rstm_tx", 32'(tx), 32'd1);
        chk("rstm_level", 32'(level), 32'd0);
        chk("rstm_busy", 32'(busy), 32'd0);
        step("rstm_hold");
        step("rstm_hold");
        #3 rst_n = 1'b1;
        for (int i = 0; i < 2 * FL; i++) step("rstm_after");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte-oriented UART transmitter with a small input FIFO for the TinyTapeout user project. It is the transmit direction of the project's serial link: the core logic pushes bytes over a valid/ready handshake, and the block serialises them as 8N1 frames (LSB first) onto one `uo_out` pin. The top-level wrapper connects `clk`, `rst_n` and `ena` straight through from the `tt_um_*` ports.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit; legal range ≥ 2.
- `FIFO_DEPTH`, default 4: FIFO entries; power of two, ≥ 2.

- `clk`  in  1: system clock; all state changes on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `ena`  in  1: TinyTapeout design enable. When low, the block is frozen.
- `in_data`  in  8: byte to transmit.
- `in_valid`  in  1: `in_data` is valid.
- `in_ready`  out  1: combinational; `ena && !full`.
- `tx`  out  1: serial line, idles high. Registered.
- `busy`  out  1: high when the FSM is not IDLE or the FIFO is not empty.
- `level`  out  $clog2(FIFO_DEPTH)+1: current FIFO occupancy.

## Operation
- **Push.** A byte is written on a clock edge where `in_valid && in_ready`. When the FIFO is full, `in_ready` is low, even if a pop happens in the same cycle.
- **FSM states:** IDLE, START, DATA, (PARITY), STOP.
- **IDLE.**
  - `tx` = 1.
  - If `level != 0`, pop the head into the shift register, clear the bit counter, and go to START.
- **START.** `tx` = 0 for `CLKS_PER_BIT` cycles, then go to DATA.
- **DATA.**
  - `tx` = shift register bit 0, sent LSB first.
  - Shift right every `CLKS_PER_BIT` cycles.
  - After 8 bits, go to STOP (or PARITY if compiled in).
- **STOP.**
  - `tx` = 1 for `CLKS_PER_BIT` cycles.
  - On its last cycle, if the FIFO is not empty, pop and go directly to START. Back-to-back frames have no idle gap.
  - Otherwise go to IDLE.
- **Baud counter.** Counts 0..`CLKS_PER_BIT`-1 and wraps. The wrap marks the end of a bit. The counter resets to 0 on every state entry from IDLE.
- **Simultaneous push and pop** (FIFO not full): `level` is unchanged and data order is preserved.
- **`ena` low:**
  - FSM, baud counter and FIFO pointers are all held.
  - `tx` holds its current value.
  - `in_ready` is 0, so no pushes are accepted.
  - Operation resumes exactly where it stopped; the current bit is stretched by the number of disabled cycles.
- **Reset**, asynchronous and effective mid-frame:
  - `tx`=1, `busy`=0, `level`=0, FSM=IDLE, pointers=0, counters=0.
  - Any frame in progress is truncated and FIFO contents are discarded.
  - While `rst_n` is low, `in_ready` still equals `ena && !full`, i.e. it follows `ena`.

## Timing
- **Idle-to-line latency.** Byte accepted at edge N with the FIFO empty and the FSM in IDLE:
  - `level`=1 after edge N.
  - Pop at edge N+1.
  - `tx` falls after edge N+1 and is visible in cycle N+2.
- **Frame length.** 10·`CLKS_PER_BIT` cycles; 11·`CLKS_PER_BIT` with parity.
- **`busy`.** Rises the cycle after the first accepted push. Falls the cycle after STOP completes with the FIFO empty.
- **`level`.** Registered; updates on the edge following the push or pop.

## Configuration
- **`UART_TX_PARITY_EN` defined:**
  - A PARITY state is inserted between DATA and STOP.
  - `tx` = even parity (XOR of the 8 data bits) for `CLKS_PER_BIT` cycles.
- **Undefined:** no PARITY state; plain 8N1 framing.

## Structure
- **Package `uart_pkg`:**
  - State enum `uart_tx_state_t` (IDLE, START, DATA, PARITY, STOP). PARITY is always declared, so encodings stay stable across builds.
  - Constants `UART_DATA_BITS` = 8 and `UART_IDLE_LEVEL` = 1'b1.
- **Sub-module `uart_sync_fifo`:**
  - Depth-parameterised FIFO with an extra wrap bit on each pointer.
  - Ports: `push`, `pop`, `wdata`, `rdata`, `full`, `empty`, `level`.
  - `rdata` is combinational from the head entry.
  - The FSM, baud counter and shift register stay in `uart_tx_fifo`.

## Test plan
1. **Single byte.** `CLKS_PER_BIT`=4, push 0xA5 from idle.
   - `tx` falls in cycle N+2.
   - Line reads 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles, 40 cycles total.
   - `busy` drops afterwards.
2. **Back-to-back and full.** Hold `in_valid` with 0x01..0x05.
   - Four bytes accepted; `in_ready` goes low once `level`=4.
   - 0x05 is accepted after the first pop.
   - Five contiguous frames with no idle gap; bytes arrive in order.
3. **Push during pop.** Push 0x3C on the last STOP cycle of a frame with `level`=1.
   - `level` stays 1.
   - The next frame starts immediately and 0x3C follows it.
4. **`ena` gap.** Deassert `ena` for 7 cycles in DATA bit 3.
   - `tx` holds; that bit lasts 4+7 cycles.
   - `in_ready`=0 throughout the gap.
   - Frame completes correctly.
5. **Reset mid-frame.** Assert `rst_n`=0 asynchronously (between clock edges) during DATA with 2 bytes queued.
   - `tx`=1 and `level`=0 immediately.
   - After release, the line stays idle.
6. **Parity build** (`UART_TX_PARITY_EN`).
   - Push 0x07: parity bit 1, frame 44 cycles.
   - Push 0x03: parity bit 0.
